rod_move_scheduler: RTL and testbench

Sequences the four foosball player rods from one set of user controls. It decides which rod is active, drives that rod's up/down levels, and issues the rod's move-timer strobe at a frame-derived rate. It also runs a kick/retract/cooldown state machine on the selected rod. It sits between the keyboard decoder and the four per-rod movement blocks, each of which consumes one `timer_done` / `up_direction` / `down_direction` triple.

---
 rtl/rod_move_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_rod_move_scheduler.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rod_move_scheduler.sv
// rod_move_scheduler: selects one of four foosball rods from shared user keys,
// drives that rod's up/down levels and move strobe, and sequences a
// kick -> retract -> cooldown cycle on the rod that was active at kick time.
module rod_move_scheduler #(
  parameter int unsigned MOVE_DIV        = 2,
  parameter int unsigned KICK_FRAMES     = 6,
  parameter int unsigned COOLDOWN_FRAMES = 10
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       frame_tick,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_next,
  input  logic       key_prev,
  input  logic       key_kick,
  output logic [1:0] rod_sel,
  output logic [3:0] rod_timer_done,
  output logic [3:0] rod_up,
  output logic [3:0] rod_down,
  output logic [3:0] kick_out,
  output logic [3:0] kick_back,
  output logic       busy
);

  localparam logic [3:0] MOVE_LAST = 4'(MOVE_DIV - 1);
  localparam logic [5:0] KICK_LAST = 6'(KICK_FRAMES - 1);
  localparam logic [5:0] COOL_LAST = 6'(COOLDOWN_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    KICK_OUT = 2'd1,
    RETRACT  = 2'd2,
    COOLDOWN = 2'd3
  } kick_state_t;

  kick_state_t state;
  logic [5:0]  kcnt;
  logic [1:0]  kick_rod;
  logic [3:0]  mcnt;

  logic armed;
  logic next_q, prev_q, kick_q;
  logic next_edge, prev_edge, kick_edge;
  logic up_en, down_en, rod_locked;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  // Key edge detection; armed stays low for the first cycle after reset so a
  // key held through reset is absorbed into the history register, not seen as an edge.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      armed     <= 1'b0;
      next_q    <= 1'b0;
      prev_q    <= 1'b0;
      kick_q    <= 1'b0;
      next_edge <= 1'b0;
      prev_edge <= 1'b0;
      kick_edge <= 1'b0;
    end else begin
      armed     <= 1'b1;
      next_q    <= key_next;
      prev_q    <= key_prev;
      kick_q    <= key_kick;
      next_edge <= armed & key_next & ~next_q;
      prev_edge <= armed & key_prev & ~prev_q;
      kick_edge <= armed & key_kick & ~kick_q;
    end
  end

  // Active rod index; wraps naturally in 2 bits, frozen while a kick runs.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rod_sel <= '0;
    end else if (!busy && (next_edge != prev_edge)) begin
      rod_sel <= next_edge ? rod_sel + 2'd1 : rod_sel - 2'd1;
    end
  end

  // Direction qualification: opposing keys cancel, kicked rod cannot move.
  always_comb begin
    rod_locked = busy & (rod_sel == kick_rod);
    up_en      = key_up & ~key_down & ~rod_locked;
    down_en    = key_down & ~key_up & ~rod_locked;
  end

  // Registered one-hot direction levels for the active rod.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rod_up   <= '0;
      rod_down <= '0;
    end else begin
      rod_up   <= up_en   ? onehot(rod_sel) : '0;
      rod_down <= down_en ? onehot(rod_sel) : '0;
    end
  end

  // Move strobe divider: one-cycle pulse to the active rod every MOVE_DIV frames.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      mcnt           <= '0;
      rod_timer_done <= '0;
    end else begin
      rod_timer_done <= '0;
      if (frame_tick) begin
        if (mcnt == MOVE_LAST) begin
          mcnt           <= '0;
          rod_timer_done <= onehot(rod_sel);
        end else begin
          mcnt <= mcnt + 4'd1;
        end
      end
    end
  end

  // Kick FSM; outputs are loaded on the transition so they track the state register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= IDLE;
      kcnt      <= '0;
      kick_rod  <= '0;
      kick_out  <= '0;
      kick_back <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (kick_edge) begin
            state    <= KICK_OUT;
            kick_rod <= rod_sel;
            kcnt     <= '0;
            kick_out <= onehot(rod_sel);
            busy     <= 1'b1;
          end
        end
        KICK_OUT: begin
          if (frame_tick) begin
            if (kcnt == KICK_LAST) begin
              state     <= RETRACT;
              kcnt      <= '0;
              kick_out  <= '0;
              kick_back <= onehot(kick_rod);
            end else begin
              kcnt <= kcnt + 6'd1;
            end
          end
        end
        RETRACT: begin
          if (frame_tick) begin
            if (kcnt == KICK_LAST) begin
              state     <= COOLDOWN;
              kcnt      <= '0;
              kick_back <= '0;
            end else begin
              kcnt <= kcnt + 6'd1;
            end
          end
        end
        COOLDOWN: begin
          if (frame_tick) begin
            if (kcnt == COOL_LAST) begin
              state <= IDLE;
              kcnt  <= '0;
              busy  <= 1'b0;
            end else begin
              kcnt <= kcnt + 6'd1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          kcnt      <= '0;
          kick_out  <= '0;
          kick_back <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rod_move_scheduler.sv
// Directed testbench for rod_move_scheduler with default parameters
// (MOVE_DIV=2, KICK_FRAMES=6, COOLDOWN_FRAMES=10).
module tb_rod_move_scheduler;

  logic       CLK;
  logic       RESETn;
  logic       frame_tick;
  logic       key_up, key_down, key_next, key_prev, key_kick;
  logic [1:0] rod_sel;
  logic [3:0] rod_timer_done, rod_up, rod_down, kick_out, kick_back;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  rod_move_scheduler #(
    .MOVE_DIV(2),
    .KICK_FRAMES(6),
    .COOLDOWN_FRAMES(10)
  ) dut (
    .CLK(CLK),
    .RESETn(RESETn),
    .frame_tick(frame_tick),
    .key_up(key_up),
    .key_down(key_down),
    .key_next(key_next),
    .key_prev(key_prev),
    .key_kick(key_kick),
    .rod_sel(rod_sel),
    .rod_timer_done(rod_timer_done),
    .rod_up(rod_up),
    .rod_down(rod_down),
    .kick_out(kick_out),
    .kick_back(kick_back),
    .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_prev();
    key_prev = 1'b1; cyc(1); key_prev = 1'b0; cyc(2);
  endtask

  task automatic pulse_next();
    key_next = 1'b1; cyc(1); key_next = 1'b0; cyc(2);
  endtask

  task automatic frame();
    frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(1);
  endtask

  initial begin
    RESETn = 1'b0; frame_tick = 1'b0;
    key_up = 1'b0; key_down = 1'b0; key_next = 1'b1; key_prev = 1'b0; key_kick = 1'b0;

    // Reset with key_next held
    cyc(3);
    check("rst_sel", 16'(rod_sel), 16'h0);
    check("rst_outs", {rod_timer_done, rod_up, rod_down, kick_out}, 16'h0);
    check("rst_busy", {15'h0, busy}, 16'h0);
    RESETn = 1'b1;
    cyc(10);
    check("post_rst_sel", 16'(rod_sel), 16'h0);
    check("post_rst_outs", {rod_timer_done, rod_up, rod_down, kick_back}, 16'h0);
    key_next = 1'b0;
    cyc(2);
    check("release_next_sel", 16'(rod_sel), 16'h0);

    // Selection wrap via prev, with explicit 2-cycle latency on the first one
    key_prev = 1'b1; cyc(1); key_prev = 1'b0;
    check("prev_lat1", 16'(rod_sel), 16'h0);
    cyc(1);
    check("prev_lat2", 16'(rod_sel), 16'h3);
    cyc(1);
    pulse_prev(); check("prev_2", 16'(rod_sel), 16'h2);
    pulse_prev(); check("prev_1", 16'(rod_sel), 16'h1);
    pulse_prev(); check("prev_0", 16'(rod_sel), 16'h0);
    key_next = 1'b1; key_prev = 1'b1; cyc(1); key_next = 1'b0; key_prev = 1'b0; cyc(2);
    check("next_prev_same", 16'(rod_sel), 16'h0);

    // Movement on rod 2
    pulse_next(); pulse_next();
    check("sel_2", 16'(rod_sel), 16'h2);
    key_up = 1'b1; cyc(1);
    check("up_lat", 16'(rod_up), 16'h4);
    for (int k = 1; k <= 6; k++) begin
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
      if (rod_timer_done != 4'b0000) pulses++;
      check($sformatf("strobe_%0d", k), 16'(rod_timer_done), (k % 2 == 0) ? 16'h4 : 16'h0);
      check($sformatf("dir_%0d", k), {8'h0, rod_up, rod_down}, 16'h0040);
      cyc(1);
      if (rod_timer_done != 4'b0000) pulses++;
      check($sformatf("strobe_w_%0d", k), 16'(rod_timer_done), 16'h0);
    end
    check("strobe_count", 16'(pulses), 16'h3);
    key_down = 1'b1; cyc(1);
    check("both_keys", {8'h0, rod_up, rod_down}, 16'h0);
    key_up = 1'b0; key_down = 1'b0; cyc(1);

    // Kick on rod 1
    pulse_prev();
    check("sel_1", 16'(rod_sel), 16'h1);
    key_up = 1'b1; cyc(1);
    check("up_rod1", 16'(rod_up), 16'h2);
    key_kick = 1'b1; cyc(1); key_kick = 1'b0;
    check("kick_lat1", {15'h0, busy}, 16'h0);
    cyc(1);
    check("kick_lat2_out", 16'(kick_out), 16'h2);
    check("kick_lat2_busy", {15'h0, busy}, 16'h1);
    cyc(1);
    check("up_forced0", 16'(rod_up), 16'h0);
    for (int k = 1; k <= 6; k++) begin
      frame();
      check($sformatf("ko_out_%0d", k), 16'(kick_out), (k < 6) ? 16'h2 : 16'h0);
      check($sformatf("ko_back_%0d", k), 16'(kick_back), (k == 6) ? 16'h2 : 16'h0);
    end
    for (int k = 1; k <= 6; k++) begin
      frame();
      if (k == 2) begin
        key_next = 1'b1; key_kick = 1'b1; cyc(1);
        key_next = 1'b0; key_kick = 1'b0; cyc(2);
      end
      check($sformatf("rt_back_%0d", k), 16'(kick_back), (k < 6) ? 16'h2 : 16'h0);
      check($sformatf("rt_busy_%0d", k), {15'h0, busy}, 16'h1);
      check($sformatf("rt_up_%0d", k), 16'(rod_up), 16'h0);
    end
    for (int k = 1; k <= 10; k++) begin
      frame();
      check($sformatf("cd_busy_%0d", k), {15'h0, busy}, (k < 10) ? 16'h1 : 16'h0);
      check($sformatf("cd_kick_%0d", k), {8'h0, kick_out, kick_back}, 16'h0);
    end
    check("lockout_sel", 16'(rod_sel), 16'h1);
    cyc(1);
    check("up_restored", 16'(rod_up), 16'h2);
    for (int k = 1; k <= 3; k++) begin
      frame();
      check($sformatf("no_requeue_%0d", k), {7'h0, busy, kick_out, kick_back}, 16'h0);
    end
    key_up = 1'b0; cyc(1);

    // Reset mid-kick
    key_kick = 1'b1; cyc(1); key_kick = 1'b0; cyc(1);
    check("k2_out", 16'(kick_out), 16'h2);
    frame(); frame();
    RESETn = 1'b0; #1;
    check("mid_rst_out", 16'(kick_out), 16'h0);
    check("mid_rst_busy", {15'h0, busy}, 16'h0);
    check("mid_rst_sel", 16'(rod_sel), 16'h0);
    cyc(1);
    RESETn = 1'b1;
    cyc(2);
    key_kick = 1'b1; cyc(1); key_kick = 1'b0; cyc(1);
    check("k3_out", 16'(kick_out), 16'h1);
    check("k3_busy", {15'h0, busy}, 16'h1);
    for (int k = 1; k <= 6; k++) begin
      frame();
      check($sformatf("k3_out_%0d", k), 16'(kick_out), (k < 6) ? 16'h1 : 16'h0);
    end
    check("k3_back", 16'(kick_back), 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
